// File: rtl/bth_cmd_ctrl_if.sv
// UART-side handshake bundle for the Bluetooth command sequencer.
// master = receiver/transmitter side, slave = command controller.
interface bth_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (output rx_valid, output rx_data, output tx_busy,
                  input  tx_start, input  tx_data);
  modport slave  (input  rx_valid, input  rx_data, input  tx_busy,
                  output tx_start, output tx_data);
endinterface

// File: rtl/bth_cmd_ctrl.sv
// Bluetooth command sequencer: assembles 3-byte frames (opcode, argument,
// terminator), drives bulbs / 7-segment digit and returns one ACK/NAK byte per frame.
module bth_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [7:0]  NAK_BYTE    = 8'h45
) (
  input  logic               clk,
  input  logic               reset,
  bth_cmd_ctrl_if.slave      bus,
  output logic [2:0]         bulb,
  output logic [7:0]         dsply,
  output logic [1:0]         ste,
  output logic               err
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_ON  = 8'h4E;
  localparam logic [7:0] OP_OFF = 8'h46;
  localparam logic [7:0] OP_DIG = 8'h44;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GOT_OP  = 2'b01,
    S_GOT_ARG = 2'b10,
    S_RESP    = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_op, w_op_nxt;
  logic [7:0]       r_arg, w_arg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bulb, w_bulb_nxt;
  logic [7:0]       r_dsply, w_dsply_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;
  logic             r_err, w_err_nxt;

  logic             w_is_term, w_op_ok, w_arg_ok, w_expired;
  logic             w_nak, w_ack;
  logic [2:0]       w_mask;

  function automatic logic is_hex_upper(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
  endfunction

  function automatic logic arg_legal(input logic [7:0] op, input logic [7:0] b);
    if (op == OP_DIG) return is_hex_upper(b);
    return (b >= 8'h31) && (b <= 8'h33);
  endfunction

  // ASCII '0'..'9' / 'A'..'F' to nibble
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return 4'(b[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'b00000011;  4'h1: return 8'b10011111;
      4'h2: return 8'b00100101;  4'h3: return 8'b00001101;
      4'h4: return 8'b10011001;  4'h5: return 8'b01001001;
      4'h6: return 8'b01000001;  4'h7: return 8'b00011111;
      4'h8: return 8'b00000001;  4'h9: return 8'b00001001;
      4'hA: return 8'b00010001;  4'hB: return 8'b11000001;
      4'hC: return 8'b01100011;  4'hD: return 8'b10000101;
      4'hE: return 8'b01100001;  default: return 8'b01110001;
    endcase
  endfunction

  assign w_is_term = (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h0D);
  assign w_op_ok   = (bus.rx_data == OP_ON) || (bus.rx_data == OP_OFF) ||
                     (bus.rx_data == OP_DIG);
  assign w_arg_ok  = arg_legal(r_op, bus.rx_data);
  assign w_expired = (r_cnt == CNT_LAST);

  // bulb 1 is the MSB
  always_comb begin
    case (r_arg[1:0])
      2'b01:   w_mask = 3'b100;
      2'b10:   w_mask = 3'b010;
      default: w_mask = 3'b001;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_arg      <= '0;
      r_cnt      <= '0;
      r_bulb     <= '0;
      r_dsply    <= 8'b11111110;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_arg      <= w_arg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bulb     <= w_bulb_nxt;
      r_dsply    <= w_dsply_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && !w_is_term) w_state_nxt = w_op_ok ? S_GOT_OP : S_RESP;
      end
      S_GOT_OP: begin
        if (bus.rx_valid)   w_state_nxt = w_arg_ok ? S_GOT_ARG : S_RESP;
        else if (w_expired) w_state_nxt = S_RESP;
      end
      S_GOT_ARG: begin
        if (bus.rx_valid || w_expired) w_state_nxt = S_RESP;
      end
      default: begin
        if (!bus.tx_busy) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A received byte always takes priority over timeout expiry.
  always_comb begin
    w_op_nxt       = r_op;
    w_arg_nxt      = r_arg;
    w_cnt_nxt      = '0;
    w_bulb_nxt     = r_bulb;
    w_dsply_nxt    = r_dsply;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_err_nxt      = r_err;
    w_nak          = 1'b0;
    w_ack          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && !w_is_term) begin
          if (w_op_ok) w_op_nxt = bus.rx_data;
          else         w_nak    = 1'b1;
        end
      end
      S_GOT_OP: begin
        if (bus.rx_valid) begin
          if (w_arg_ok) w_arg_nxt = bus.rx_data;
          else          w_nak     = 1'b1;
        end else if (w_expired) begin
          w_nak = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GOT_ARG: begin
        if (bus.rx_valid) begin
          if (w_is_term) begin
            w_ack = 1'b1;
            if (r_op == OP_ON)       w_bulb_nxt  = r_bulb | w_mask;
            else if (r_op == OP_OFF) w_bulb_nxt  = r_bulb & ~w_mask;
            else                     w_dsply_nxt = glyph(hex_val(r_arg));
          end else begin
            w_nak = 1'b1;
          end
        end else if (w_expired) begin
          w_nak = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        if (!bus.tx_busy) w_tx_start_nxt = 1'b1;
      end
    endcase
    if (w_nak) begin
      w_tx_data_nxt = NAK_BYTE;
      w_err_nxt     = 1'b1;
    end else if (w_ack) begin
      w_tx_data_nxt = ACK_BYTE;
      w_err_nxt     = 1'b0;
    end
  end

  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bulb         = r_bulb;
  assign dsply        = r_dsply;
  assign ste          = r_state;
  assign err          = r_err;

endmodule

// File: doc/bth_cmd_ctrl.md
Name: bth_cmd_ctrl

Overview:
- Command sequencer between the Bluetooth UART byte receiver and the board actuators (3 bulbs, 7-segment digit).
- Assembles received bytes into 3-byte command frames, validates them, then updates the bulbs or the display.
- For every frame it returns one acknowledge byte through the UART transmitter handshake.
- Malformed or stalled frames are rejected with an error byte.

Parameters:
- TIMEOUT_CYC, 500000, inter-byte timeout in clk cycles (10 ms at 50 MHz); valid range ≥ 2.
- ACK_BYTE, 8'h4B, response for an executed command ('K').
- NAK_BYTE, 8'h45, response for a rejected frame ('E').

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy; a start request is only issued while low.
- tx_start  out  1  one-cycle start request to the transmitter.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until the next response.
- bulb  out  3  bulb actuators, bit2 = bulb 1, bit1 = bulb 2, bit0 = bulb 3.
- dsply  out  8  7-segment pattern abcdefgp, active-low.
- ste  out  2  current state indicator.
- err  out  1  last frame rejected.

Behaviour:
- All outputs are registered on the clk rising edge. Reset applies immediately and asynchronously, aborts any frame in progress and drops any pending response.
- Reset values: bulb=000, dsply=8'b11111110, tx_start=0, tx_data=8'h00, ste=00, err=0, state IDLE, timeout counter 0.
- Frame format: opcode, argument, terminator. The terminator is 8'h0A or 8'h0D.
  - 'N' (8'h4E), arg '1'..'3': set that bulb bit.
  - 'F' (8'h46), arg '1'..'3': clear that bulb bit.
  - 'D' (8'h44), arg '0'..'9' or 'A'..'F' (uppercase only): load the glyph.
- Glyph table:
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101
  - 4=10011001, 5=01001001, 6=01000001, 7=00011111
  - 8=00000001, 9=00001001, A=00010001, b=11000001
  - C=01100011, d=10000101, E=01100001, F=01110001
- FSM states (ste encoding): IDLE 00, GOT_OP 01, GOT_ARG 10, RESP 11.
- IDLE:
  - rx_valid with a terminator: ignored, so CR+LF pairs are harmless.
  - rx_valid with a legal opcode: latch it, go to GOT_OP.
  - rx_valid with any other byte: tx_data=NAK_BYTE, go to RESP.
- GOT_OP:
  - rx_valid with an argument legal for the latched opcode: latch it, go to GOT_ARG.
  - rx_valid with any other byte: NAK, go to RESP.
- GOT_ARG:
  - rx_valid with a terminator: execute on the same edge (bulb/dsply update), tx_data=ACK_BYTE, go to RESP.
  - rx_valid with any other byte: NAK, go to RESP; bulb/dsply unchanged.
- Timeout:
  - Counter clears on every accepted byte and runs only in GOT_OP and GOT_ARG.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid: NAK, go to RESP; the partial frame is discarded.
  - If rx_valid and expiry occur in the same cycle, the byte wins.
- RESP:
  - On the first edge where tx_busy=0 is sampled: tx_start=1 for exactly the next cycle, then IDLE.
  - While tx_busy=1: wait indefinitely; tx_start stays 0.
  - rx_valid during RESP: the byte is discarded and not buffered.
- err: set to 1 on the edge that selects NAK, cleared to 0 on the edge that selects ACK.
- Latency: terminator edge → bulb/dsply visible next cycle → tx_start asserted the cycle after, with tx_busy low.
- Repeated commands: 'N' on an already-set bulb and 'F' on an already-clear bulb are legal; they produce an ACK and no change.

Test Plan:
- 'N','2',0x0A with tx_busy=0 → bulb=010, one tx_start pulse with tx_data=8'h4B, err=0, ste returns 00.
- 'D','7',0x0D then 'F','2',0x0A after the first case → dsply=00011111, then bulb=000; two ACK pulses.
- 'X' → immediate NAK pulse (8'h45), err=1; then 'N','1',0x0A → bulb=100, err=0.
- TIMEOUT_CYC=100: 'N' then idle 120 cycles → NAK asserted exactly 100 cycles after 'N' was accepted, bulb unchanged, ste=00.
- Two further timeout checks with TIMEOUT_CYC=100:
  - 'N' then '3' arriving on the expiry cycle → accepted, no NAK.
  - 'N','1','1' → NAK.
- tx_busy=1 for 50 cycles in RESP, and rx_valid 'N' during the wait → no tx_start until tx_busy falls, then exactly one pulse; the 'N' is ignored, ste=00 afterwards.
- Reset mid-frame:
  - Sequence: 'N','1',0x0A, then 'D','5', then reset, then 'N','3',0x0A.
  - Asserting reset mid-frame (mid-cycle) → all outputs return to reset values without waiting for clk.
  - Subsequent 'N','3',0x0A → bulb=001, dsply=11111110.
